// File: rtl/dpram_gen_pkg.sv
// Shared definitions for the dual-port RAM: read-during-write mode codes,
// clear-sequencer state encoding and the address-width helper.
package dpram_gen_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bits needed to hold 'value'; never less than one so a 1-word RAM still has an address.
    function automatic int clogb2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) begin
                res = i + 1;
            end
        end
        if (res < 1) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_port_pipe.sv
// Per-port read path: read-during-write selection, out-of-range masking,
// optional output register and rvalid generation.
module dpram_port_pipe
    import dpram_gen_pkg::*;
#(
    parameter int RAM_WIDTH = 32,
    parameter int OUT_REG   = 0,
    parameter int RDW_MODE  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 act_i,
    input  logic                 we_i,
    input  logic                 in_range_i,
    input  logic [RAM_WIDTH-1:0] rd_word_i,
    input  logic [RAM_WIDTH-1:0] merged_i,
    output logic [RAM_WIDTH-1:0] dout_o,
    output logic                 rvalid_o
);

    logic                 load_s;
    logic [RAM_WIDTH-1:0] data_s;
    logic [RAM_WIDTH-1:0] rd_m_s;
    logic [RAM_WIDTH-1:0] mg_m_s;
    logic [RAM_WIDTH-1:0] s1_data_q;
    logic [RAM_WIDTH-1:0] s1_data_d;
    logic                 s1_vld_q;

    // Out-of-range accesses always present an all-zero word.
    assign rd_m_s = in_range_i ? rd_word_i : '0;
    assign mg_m_s = in_range_i ? merged_i  : '0;

    always_comb begin
        load_s = 1'b0;
        data_s = '0;
        if (act_i && !we_i) begin
            load_s = 1'b1;
            data_s = rd_m_s;
        end else if (act_i) begin
            case (RDW_MODE)
                RDW_READ_FIRST: begin
                    load_s = 1'b1;
                    data_s = rd_m_s;
                end
                RDW_WRITE_FIRST: begin
                    load_s = 1'b1;
                    data_s = mg_m_s;
                end
                RDW_NO_CHANGE: begin
                    load_s = 1'b0;
                end
                default: begin
                    load_s = 1'b0;
                end
            endcase
        end else begin
            load_s = 1'b0;
        end
        s1_data_d = load_s ? data_s : s1_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= load_s;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [RAM_WIDTH-1:0] s2_data_q;
        logic                 s2_vld_q;

        // Free-running second stage; data only moves when the first stage held a valid word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_data_q <= '0;
                s2_vld_q  <= 1'b0;
            end else begin
                s2_vld_q  <= s1_vld_q;
                s2_data_q <= s1_vld_q ? s1_data_q : s2_data_q;
            end
        end

        assign dout_o   = s2_data_q;
        assign rvalid_o = s2_vld_q;
    end else begin : g_noreg
        assign dout_o   = s1_data_q;
        assign rvalid_o = s1_vld_q;
    end

endmodule

// File: rtl/dpram_gen.sv
// Parametrised true-dual-port RAM with byte enables, clear sequencer and
// cross-port collision flags; both ports run on one clock.
module dpram_gen
    import dpram_gen_pkg::*;
#(
    parameter int                   RAM_WIDTH  = 32,
    parameter int                   RAM_DEPTH  = 65536,
    parameter int                   OUT_REG    = 0,
    parameter int                   RDW_MODE_A = 2,
    parameter int                   RDW_MODE_B = 2,
    parameter int                   INIT_EN    = 1,
    parameter logic [RAM_WIDTH-1:0] INIT_VAL   = '0,
    localparam int                  BE_W       = RAM_WIDTH / 8,
    localparam int                  ADDR_W     = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_req,
    output logic                 init_busy,
    input  logic                 ena,
    input  logic                 wea,
    input  logic [BE_W-1:0]      wema,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    output logic [RAM_WIDTH-1:0] douta,
    output logic                 rvalida,
    input  logic                 enb,
    input  logic                 web,
    input  logic [BE_W-1:0]      wemb,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic [RAM_WIDTH-1:0] dinb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 rvalidb,
    output logic                 coll_wr,
    output logic                 coll_rw
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
    localparam state_e            RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    ctr_q, ctr_d;
    logic                 init_wr_s;
    logic                 act_a_s, act_b_s, wr_a_s, wr_b_s;
    logic                 in_range_a_s, in_range_b_s;
    logic [RAM_WIDTH-1:0] rd_a_s, rd_b_s, merged_a_s, merged_b_s;
    logic                 coll_wr_q, coll_wr_d, coll_rw_q, coll_rw_d;

    if (RAM_DEPTH == (1 << ADDR_W)) begin : g_pow2
        assign in_range_a_s = 1'b1;
        assign in_range_b_s = 1'b1;
    end else begin : g_npow2
        assign in_range_a_s = (addra <= LAST_ADDR);
        assign in_range_b_s = (addrb <= LAST_ADDR);
    end

    assign init_busy = (state_q == ST_INIT);
    assign act_a_s   = ena & (state_q == ST_RUN);
    assign act_b_s   = enb & (state_q == ST_RUN);
    assign wr_a_s    = act_a_s & wea & in_range_a_s;
    assign wr_b_s    = act_b_s & web & in_range_b_s;
    assign rd_a_s    = in_range_a_s ? mem_q[addra] : '0;
    assign rd_b_s    = in_range_b_s ? mem_q[addrb] : '0;

    // Post-write word as each port sees its own write land on the pre-write word.
    always_comb begin
        merged_a_s = rd_a_s;
        merged_b_s = rd_b_s;
        for (int i = 0; i < BE_W; i++) begin
            if (wema[i]) begin
                merged_a_s[i*8 +: 8] = dina[i*8 +: 8];
            end else begin
                merged_a_s[i*8 +: 8] = rd_a_s[i*8 +: 8];
            end
            if (wemb[i]) begin
                merged_b_s[i*8 +: 8] = dinb[i*8 +: 8];
            end else begin
                merged_b_s[i*8 +: 8] = rd_b_s[i*8 +: 8];
            end
        end
    end

    // Port A's byte writes are issued last so they win on a same-address collision.
    always_ff @(posedge clk) begin
        if (init_wr_s) begin
            mem_q[ctr_q] <= INIT_VAL;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_b_s && wemb[i]) begin
                    mem_q[addrb][i*8 +: 8] <= dinb[i*8 +: 8];
                end
                if (wr_a_s && wema[i]) begin
                    mem_q[addra][i*8 +: 8] <= dina[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        init_wr_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr_s = 1'b1;
                if (ctr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_d = ST_INIT;
                    ctr_d   = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                ctr_d   = '0;
            end
        endcase
    end

    always_comb begin
        coll_wr_d = 1'b0;
        coll_rw_d = 1'b0;
        if (act_a_s && act_b_s && (addra == addrb)) begin
            coll_wr_d = wea & web;
            coll_rw_d = wea ^ web;
        end else begin
            coll_wr_d = 1'b0;
            coll_rw_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            ctr_q     <= '0;
            coll_wr_q <= 1'b0;
            coll_rw_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            coll_wr_q <= coll_wr_d;
            coll_rw_q <= coll_rw_d;
        end
    end

    assign coll_wr = coll_wr_q;
    assign coll_rw = coll_rw_q;

    dpram_port_pipe #(
        .RAM_WIDTH (RAM_WIDTH),
        .OUT_REG   (OUT_REG),
        .RDW_MODE  (RDW_MODE_A)
    ) u_pipe_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .act_i      (act_a_s),
        .we_i       (wea),
        .in_range_i (in_range_a_s),
        .rd_word_i  (rd_a_s),
        .merged_i   (merged_a_s),
        .dout_o     (douta),
        .rvalid_o   (rvalida)
    );

    dpram_port_pipe #(
        .RAM_WIDTH (RAM_WIDTH),
        .OUT_REG   (OUT_REG),
        .RDW_MODE  (RDW_MODE_B)
    ) u_pipe_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .act_i      (act_b_s),
        .we_i       (web),
        .in_range_i (in_range_b_s),
        .rd_word_i  (rd_b_s),
        .merged_i   (merged_b_s),
        .dout_o     (doutb),
        .rvalid_o   (rvalidb)
    );

endmodule

// File: tb/tb_dpram_gen.sv
// Directed bench: three RAM configurations share one stimulus bus and are
// checked against hand-computed words.
module tb_dpram_gen;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n, clr_req;
    logic        ena, wea, enb, web;
    logic [3:0]  wema, wemb, addra, addrb;
    logic [31:0] dina, dinb;

    logic        busy    [3];
    logic [31:0] douta   [3];
    logic [31:0] doutb   [3];
    logic        rvalida [3];
    logic        rvalidb [3];
    logic        coll_wr [3];
    logic        coll_rw [3];

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc;

    always #5 clk = ~clk;

    // u0: write-first A / no-change B, latency 1
    dpram_gen #(.RAM_WIDTH(32), .RAM_DEPTH(16), .OUT_REG(0), .RDW_MODE_A(1), .RDW_MODE_B(2),
                .INIT_EN(1), .INIT_VAL(IV)) u0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(busy[0]),
        .ena(ena), .wea(wea), .wema(wema), .addra(addra), .dina(dina), .douta(douta[0]), .rvalida(rvalida[0]),
        .enb(enb), .web(web), .wemb(wemb), .addrb(addrb), .dinb(dinb), .doutb(doutb[0]), .rvalidb(rvalidb[0]),
        .coll_wr(coll_wr[0]), .coll_rw(coll_rw[0]));

    // u1: no-change A / read-first B, latency 2
    dpram_gen #(.RAM_WIDTH(32), .RAM_DEPTH(16), .OUT_REG(1), .RDW_MODE_A(2), .RDW_MODE_B(0),
                .INIT_EN(1), .INIT_VAL(IV)) u1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(busy[1]),
        .ena(ena), .wea(wea), .wema(wema), .addra(addra), .dina(dina), .douta(douta[1]), .rvalida(rvalida[1]),
        .enb(enb), .web(web), .wemb(wemb), .addrb(addrb), .dinb(dinb), .doutb(doutb[1]), .rvalidb(rvalidb[1]),
        .coll_wr(coll_wr[1]), .coll_rw(coll_rw[1]));

    // u2: depth 12, no clear after reset, read-first both ports
    dpram_gen #(.RAM_WIDTH(32), .RAM_DEPTH(12), .OUT_REG(0), .RDW_MODE_A(0), .RDW_MODE_B(0),
                .INIT_EN(0), .INIT_VAL(32'h0)) u2 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(busy[2]),
        .ena(ena), .wea(wea), .wema(wema), .addra(addra), .dina(dina), .douta(douta[2]), .rvalida(rvalida[2]),
        .enb(enb), .web(web), .wemb(wemb), .addrb(addrb), .dinb(dinb), .doutb(doutb[2]), .rvalidb(rvalidb[2]),
        .coll_wr(coll_wr[2]), .coll_rw(coll_rw[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; wea = 1'b0; wema = 4'h0;
        enb = 1'b0; web = 1'b0; wemb = 4'h0;
        clr_req = 1'b0;
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        ena = 1'b1; wea = 1'b1; addra = a; dina = d; wema = m;
        step();
        idle();
    endtask

    task automatic rd_a(input logic [3:0] a);
        ena = 1'b1; wea = 1'b0; addra = a;
        step();
        idle();
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (busy[0] && n < 100) begin
            step();
            n++;
        end
    endtask

    // Streams addresses 0..15 through port A; u1 answers one cycle behind u0.
    task automatic sweep_init_val(input string tag);
        for (int a = 0; a <= 16; a++) begin
            ena = (a < 16); wea = 1'b0; addra = 4'(a);
            step();
            if (a < 16) check_eq({tag, "_u0"}, douta[0], IV);
            if (a >= 1)  check_eq({tag, "_u1"}, douta[1], IV);
        end
        check_eq({tag, "_u1_vld"}, 32'(rvalida[1]), 32'd1);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        addra = 4'h0; addrb = 4'h0; dina = 32'h0; dinb = 32'h0;
        repeat (3) step();
        check_eq("rst_busy_u0", 32'(busy[0]), 32'd1);
        check_eq("rst_busy_u1", 32'(busy[1]), 32'd1);
        check_eq("rst_busy_u2", 32'(busy[2]), 32'd0);
        check_eq("rst_douta",   douta[0], 32'h0);
        check_eq("rst_rvalid",  32'(rvalida[1]), 32'd0);
        check_eq("rst_coll",    32'(coll_wr[0]), 32'd0);

        // Clear after reset: exactly RAM_DEPTH busy cycles, then every word is INIT_VAL.
        rst_n = 1'b1;
        wait_init(n_cyc);
        check_eq("init_cycles", 32'(n_cyc), 32'd16);
        check_eq("init_done_u1", 32'(busy[1]), 32'd0);
        sweep_init_val("init_rd");

        // Byte-enabled write, then latency 1 vs 2 and output hold.
        wr_a(4'd5, 32'h0, 4'hF);
        wr_a(4'd5, 32'h11223344, 4'b0101);
        rd_a(4'd5);
        check_eq("be_u0_data", douta[0], 32'h00220044);
        check_eq("be_u0_vld",  32'(rvalida[0]), 32'd1);
        check_eq("be_u1_lat1", 32'(rvalida[1]), 32'd0);
        step();
        check_eq("be_u1_vld",  32'(rvalida[1]), 32'd1);
        check_eq("be_u1_data", douta[1], 32'h00220044);
        check_eq("hold_u0_vld",  32'(rvalida[0]), 32'd0);
        check_eq("hold_u0_data", douta[0], 32'h00220044);

        // Both ports write addr 3: overlapping byte 1 goes to port A.
        wr_a(4'd3, 32'h0, 4'hF);
        ena = 1'b1; wea = 1'b1; addra = 4'd3; dina = 32'hFFFFFFFF; wema = 4'b0011;
        enb = 1'b1; web = 1'b1; addrb = 4'd3; dinb = 32'h12345678; wemb = 4'b0110;
        step();
        idle();
        check_eq("cwr_u0",    32'(coll_wr[0]), 32'd1);
        check_eq("cwr_rw_u0", 32'(coll_rw[0]), 32'd0);
        check_eq("cwr_u2",    32'(coll_wr[2]), 32'd1);
        step();
        check_eq("cwr_pulse", 32'(coll_wr[0]), 32'd0);
        rd_a(4'd3);
        check_eq("cwr_word_u0", douta[0], 32'h0034FFFF);
        check_eq("cwr_word_u2", douta[2], 32'h0034FFFF);

        // A writes addr 7 while B reads it.
        wr_a(4'd7, 32'hCAFE0000, 4'hF);
        ena = 1'b1; wea = 1'b1; addra = 4'd7; dina = 32'h0000BEEF; wema = 4'hF;
        enb = 1'b1; web = 1'b0; addrb = 4'd7;
        step();
        idle();
        check_eq("crw_doutb_u0",  doutb[0], 32'hCAFE0000);
        check_eq("crw_rvalidb",   32'(rvalidb[0]), 32'd1);
        check_eq("crw_flag",      32'(coll_rw[0]), 32'd1);
        check_eq("rdw_wf_douta",  douta[0], 32'h0000BEEF);
        check_eq("rdw_wf_vld",    32'(rvalida[0]), 32'd1);
        check_eq("rdw_rf_douta",  douta[2], 32'hCAFE0000);
        check_eq("rdw_nc_vld1",   32'(rvalida[1]), 32'd0);
        step();
        check_eq("crw_doutb_u1",  doutb[1], 32'hCAFE0000);
        check_eq("crw_rvalidb_u1", 32'(rvalidb[1]), 32'd1);
        check_eq("rdw_nc_vld2",   32'(rvalida[1]), 32'd0);
        check_eq("crw_pulse",     32'(coll_rw[0]), 32'd0);

        // Depth 12: address 13 is outside u2 but inside u0.
        for (int i = 0; i < 12; i++) wr_a(4'(i), 32'h10000000 + 32'(i), 4'hF);
        wr_a(4'd13, 32'hFFFFFFFF, 4'hF);
        rd_a(4'd13);
        check_eq("oor_u2_data", douta[2], 32'h0);
        check_eq("oor_u2_vld",  32'(rvalida[2]), 32'd1);
        check_eq("oor_u0_data", douta[0], 32'hFFFFFFFF);
        for (int i = 0; i < 12; i++) begin
            rd_a(4'(i));
            check_eq("oor_keep_u2", douta[2], 32'h10000000 + 32'(i));
        end

        // On-demand clear interrupted by reset restarts from word 0.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check_eq("clr_busy_u0", 32'(busy[0]), 32'd1);
        check_eq("clr_busy_u2", 32'(busy[2]), 32'd1);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        wait_init(n_cyc);
        check_eq("reclr_cycles", 32'(n_cyc), 32'd16);
        check_eq("reclr_u2_run", 32'(busy[2]), 32'd0);
        sweep_init_val("reclr_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dpram_gen.md
Name: dpram_gen

Overview:
Parametrised true-dual-port synchronous RAM, successor to the core's fixed 32-bit TCM RAM. Adds the following:
- generic width and byte-enable count
- optional output register stage
- per-port read-during-write mode
- cross-port collision resolution and flags
- a post-reset/on-demand clear sequencer
Sits under the instruction/data TCM wrappers; both ports share one clock.

Parameters:
RAM_WIDTH, 32, data width in bits; must be a multiple of 8; BE_W = RAM_WIDTH/8
RAM_DEPTH, 65536, number of words; ADDR_W = clogb2(RAM_DEPTH-1)
OUT_REG, 0, 0: read latency 1; 1: extra output register, read latency 2
RDW_MODE_A, 2, port A read-during-write: 0 read-first, 1 write-first, 2 no-change
RDW_MODE_B, 2, same for port B
INIT_EN, 1, 1: run the clear sequence after reset release
INIT_VAL, 0, word value written by the clear sequence

Ports:
clk  in  1  single clock for both ports
rst_n  in  1  asynchronous active-low reset
clr_req  in  1  one-cycle request to re-run the clear sequence
init_busy  out  1  clear sequence in progress; ports ignored
ena  in  1  port A enable
wea  in  1  port A write (else read)
wema  in  BE_W  port A byte enables
addra  in  ADDR_W  port A address
dina  in  RAM_WIDTH  port A write data
douta  out  RAM_WIDTH  port A read data
rvalida  out  1  douta carries new data this cycle
enb, web, wemb, addrb, dinb, doutb, rvalidb: port B equivalents
coll_wr  out  1  both ports wrote the same address (registered pulse)
coll_rw  out  1  one port wrote, the other read the same address (registered pulse)

Behaviour:
- Reset values: douta/doutb/pipeline registers = 0; rvalida/rvalidb = 0; coll_wr/coll_rw = 0. The memory array is not reset.
- init_busy = 1 during reset if INIT_EN = 1, else 0.
- FSM states: INIT and RUN.
  - Reset: go to INIT if INIT_EN = 1, else RUN.
  - INIT: ctr starts at 0. Each cycle writes INIT_VAL to word ctr, then ctr++.
  - After writing word RAM_DEPTH-1, go to RUN next cycle. Clear takes exactly RAM_DEPTH cycles.
  - init_busy = (state == INIT).
  - RUN with clr_req = 1: go to INIT next cycle with ctr = 0.
  - clr_req while in INIT: ignored.
  - rst_n low mid-INIT: sequence aborts; restarts from 0 after release.
- In INIT, all port inputs are ignored and no rvalid is produced.
- Read: en & !we in cycle N gives dout and rvalid = 1 in cycle N+1 (OUT_REG = 0) or N+2 (OUT_REG = 1). dout holds its last value when rvalid = 0.
- Write: en & we writes byte i iff wem[i]. wem = 0 performs no memory change but still counts as a write.
- Output on a write, by RDW mode:
  - mode 0: dout = pre-write word, rvalid = 1
  - mode 1: dout = merged post-write word, rvalid = 1
  - mode 2: dout unchanged, rvalid = 0
- Same cycle, same address, both ports writing:
  - bytes enabled on both ports take port A data
  - bytes enabled on one port only take that port's data
  - coll_wr = 1 in the next cycle
- Same cycle, same address, one port writing and the other reading:
  - the reader gets the pre-write word
  - coll_rw = 1 in the next cycle
- Collision flags are evaluated only when both ports are enabled in RUN; they are one-cycle pulses.
- Addresses >= RAM_DEPTH (non-power-of-2 depth): writes are dropped; reads return 0 with rvalid = 1.
- With OUT_REG = 1, the pipeline advances every cycle with no stall. rvalid is shifted alongside the data.

Decomposition:
- Shared include dpram_defs.vh holds:
  - RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1, RDW_NO_CHANGE = 2
  - the clogb2 function
  - FSM state encodings (INIT = 1'b0, RUN = 1'b1)
- One sub-module, dpram_port_pipe, instantiated once per port. It does:
  - RDW selection
  - out-of-range masking
  - the OUT_REG stage
  - rvalid generation
- The array, clear sequencer and collision logic stay in dpram_gen.

Test Plan:
- INIT_EN = 1, RAM_DEPTH = 16, INIT_VAL = 32'hA5A5A5A5, release rst_n → init_busy high exactly 16 cycles; afterwards reads of addresses 0..15 return A5A5A5A5.
- Port A write 0x11223344 to addr 5 with wema = 4'b0101, word previously 0 → read returns 0x00220044. With OUT_REG = 1, rvalida arrives 2 cycles after the read request.
- Port A writes 0xFFFFFFFF (wema = 4'b0011) and port B writes 0x12345678 (wemb = 4'b0110) to addr 3 in the same cycle → word = 0x0034FFFF; coll_wr pulses 1 cycle later.
- Word at addr 7 = 0xCAFE0000; port A writes 0x0000BEEF (wema = 4'b1111) while port B reads addr 7 → doutb = 0xCAFE0000, coll_rw = 1. RDW_MODE_A = 1 gives douta = 0x0000BEEF; mode 2 gives no rvalida.
- clr_req pulse in RUN, then rst_n asserted at clear cycle 5 → after release init_busy stays high a full 16 cycles and all words equal INIT_VAL.
- INIT_EN = 0, RAM_DEPTH = 12, read addr 13 → rvalid = 1, dout = 0; write to addr 13 does not disturb any word 0..11.
